// File: rtl/conv2d_stream_unpacker_if.sv
// Stream bundle around the conv2d output unpacker.
//   in_*  : IN_W-bit pixel-vector stream (valid/ready) into the unpacker
//   m_*   : OUT_W-bit beat stream (valid/ready/last/user) out of the unpacker
// master : the unpacker side (sinks in_*, sources m_*)
// slave  : the environment side (sources in_*, sinks m_*)
interface conv2d_stream_unpacker_if #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 64
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             m_user;

    modport master (
        input  in_data, in_valid, m_ready,
        output in_ready, m_data, m_valid, m_last, m_user
    );

    modport slave (
        output in_data, in_valid, m_ready,
        input  in_ready, m_data, m_valid, m_last, m_user
    );
endinterface

// File: rtl/conv2d_stream_unpacker.sv
// conv2d_stream_unpacker
// Takes IN_W-bit activated pixel vectors and re-emits each one as BEATS
// OUT_W-bit beats (low slice first), tracking the output-frame position so
// the first beat of a frame carries m_user (SOF) and the final beat carries
// m_last. A frame_done pulse and a wrapping frame_count follow each frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : in_* vector stream and m_* beat stream (master modport)
//   frame_done  : one-cycle pulse the cycle after the m_last handshake
//   frame_count : completed frames, wraps at 2^16
module conv2d_stream_unpacker #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 64,
    parameter int IMG_OUT_W = 30,
    parameter int IMG_OUT_H = 30
) (
    input  logic                            clk,
    input  logic                            rst,
    conv2d_stream_unpacker_if.master        bus,
    output logic                            frame_done,
    output logic [15:0]                     frame_count
);
    localparam int BEATS = IN_W / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = (IMG_OUT_W > 1) ? $clog2(IMG_OUT_W) : 1;
    localparam int RW    = (IMG_OUT_H > 1) ? $clog2(IMG_OUT_H) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_q, state_d;
    logic [BEATS-1:0][OUT_W-1:0]   hold_q;
    logic [BW-1:0]                 beat_q;
    logic [CW-1:0]                 col_q;
    logic [RW-1:0]                 row_q;
    // Held low through reset and for one cycle after it, so in_ready only
    // rises the cycle after rst is released.
    logic                          run_q;

    logic in_rdy, load, beat_inc, pos_adv;
    logic last_beat, first_pix, last_pix, out_xfer;

    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign first_pix = (col_q == '0) && (row_q == '0);
    assign last_pix  = (col_q == CW'(IMG_OUT_W - 1)) && (row_q == RW'(IMG_OUT_H - 1));

    assign bus.m_valid  = (state_q == SEND);
    assign bus.m_data   = hold_q[beat_q];
    assign bus.m_user   = bus.m_valid && first_pix && (beat_q == '0);
    assign bus.m_last   = bus.m_valid && last_pix && last_beat;
    assign bus.in_ready = in_rdy;
    assign out_xfer     = bus.m_valid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake decode. In SEND a new vector is only taken
    // together with the final-beat handshake, which gives back-to-back
    // vectors with no bubble (in_ready depends combinationally on m_ready).
    always_comb begin
        state_d  = state_q;
        in_rdy   = 1'b0;
        load     = 1'b0;
        beat_inc = 1'b0;
        pos_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = run_q;
                if (run_q && bus.in_valid) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                in_rdy = last_beat && bus.m_ready;
                if (bus.m_ready) begin
                    if (!last_beat) begin
                        beat_inc = 1'b1;
                    end else begin
                        pos_adv = 1'b1;
                        if (bus.in_valid) load    = 1'b1;
                        else              state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            beat_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            run_q       <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            run_q      <= 1'b1;
            frame_done <= out_xfer && bus.m_last;
            if (out_xfer && bus.m_last)
                frame_count <= frame_count + 16'd1;

            if (load) begin
                hold_q <= bus.in_data;
                beat_q <= '0;
            end else if (beat_inc) begin
                beat_q <= beat_q + BW'(1);
            end

            // Position advances once per completed vector; wrapping both
            // counters at frame end makes the next vector the SOF.
            if (pos_adv) begin
                if (col_q == CW'(IMG_OUT_W - 1)) begin
                    col_q <= '0;
                    if (row_q == RW'(IMG_OUT_H - 1)) row_q <= '0;
                    else                              row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv2d_stream_unpacker.sv
module tb_conv2d_stream_unpacker;
    localparam int PIX = 900;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_done;
    logic [15:0] frame_count;

    conv2d_stream_unpacker_if #(.IN_W(128), .OUT_W(64)) bus ();

    conv2d_stream_unpacker #(
        .IN_W(128), .OUT_W(64), .IMG_OUT_W(30), .IMG_OUT_H(30)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Reference model: a queue of expected beats built from every accepted
    // vector, with SOF/EOF derived from the pixel index within the frame.
    typedef struct {
        logic [63:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    int          pix_in = 0;
    logic        fd_exp = 1'b0;
    logic [15:0] fc_m = '0;
    int          beats, last_cnt, user_cnt, last_at;
    longint      cyc = 0, first_cyc, last_cyc;

    task automatic clr_stats();
        beats = 0; last_cnt = 0; user_cnt = 0; last_at = 0;
        first_cyc = 0; last_cyc = 0;
    endtask

    initial begin
        beat_t       e;
        logic        pstall;
        logic [63:0] pd;
        logic        pu, pl;
        pstall = 1'b0; pd = '0; pu = 1'b0; pl = 1'b0;
        clr_stats();
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            chk("frame_done", {127'd0, frame_done}, {127'd0, fd_exp});
            chk("frame_count", {112'd0, frame_count}, {112'd0, fc_m});
            if (pstall) begin
                chk("stall_valid", {127'd0, bus.m_valid}, 128'd1);
                chk("stall_data", {64'd0, bus.m_data}, {64'd0, pd});
                chk("stall_user", {127'd0, bus.m_user}, {127'd0, pu});
                chk("stall_last", {127'd0, bus.m_last}, {127'd0, pl});
            end
            if (rst) begin
                exp_q.delete();
                pix_in = 0; fd_exp = 1'b0; fc_m = '0; pstall = 1'b0;
            end else begin
                fd_exp = 1'b0;
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", {64'd0, bus.m_data}, {64'd0, e.d});
                        chk("beat_user", {127'd0, bus.m_user}, {127'd0, e.u});
                        chk("beat_last", {127'd0, bus.m_last}, {127'd0, e.l});
                        if (e.l) begin fd_exp = 1'b1; fc_m++; end
                    end
                    beats++;
                    if (beats == 1) first_cyc = cyc;
                    last_cyc = cyc;
                    if (bus.m_last) begin last_cnt++; last_at = beats; end
                    if (bus.m_user) user_cnt++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    for (int b = 0; b < 2; b++) begin
                        e.d = bus.in_data[b*64 +: 64];
                        e.u = (pix_in % PIX == 0) && (b == 0);
                        e.l = (pix_in % PIX == PIX - 1) && (b == 1);
                        exp_q.push_back(e);
                    end
                    pix_in++;
                end
                pstall = bus.m_valid && !bus.m_ready;
                pd = bus.m_data; pu = bus.m_user; pl = bus.m_last;
            end
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; bus.in_valid = 1'b0; bus.m_ready = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        clr_stats();
    endtask

    // Random valid/ready driver; holds in_data stable until accepted and
    // returns once n vectors are in and every expected beat has drained.
    task automatic run_stream(input int n, input int pv, input int pr, input int maxc);
        int sent = 0;
        int c = 0;
        bit acc = 1'b0;
        forever begin
            @(negedge clk);
            if (sent == n && exp_q.size() == 0) break;
            c++;
            if (c > maxc) begin
                fail_now("stream_timeout");
                break;
            end
            if (!bus.in_valid || acc) begin
                if (sent < n && int'($urandom_range(99)) < pv) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.m_ready = (int'($urandom_range(99)) < pr);
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        bus.m_ready  = 1'b1;
    endtask

    typedef struct {
        logic        rst, iv, mr;
        logic [127:0] d;
        logic        ir, mv, chkd, mu, ml;
        logic [63:0] md;
    } vec_t;

    localparam logic [127:0] V = 128'h0F0E0D0C0B0A09080706050403020100;

    initial begin
        vec_t        tv[8];
        logic [127:0] v2;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.m_ready  = 1'b0;

        //          rst   iv    mr    data  ir    mv    chkd  mu    ml    m_data
        tv[0] = '{1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
        tv[1] = '{1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
        tv[2] = '{1'b1, 1'b1, 1'b1, V,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
        tv[3] = '{1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
        tv[4] = '{1'b0, 1'b1, 1'b1, V,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tv[5] = '{1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0706050403020100};
        tv[6] = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0F0E0D0C0B0A0908};
        tv[7] = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = tv[i].rst; bus.in_valid = tv[i].iv;
            bus.in_data = tv[i].d; bus.m_ready = tv[i].mr;
            #1;
            chk($sformatf("tv%0d_in_ready", i), {127'd0, bus.in_ready}, {127'd0, tv[i].ir});
            chk($sformatf("tv%0d_m_valid", i), {127'd0, bus.m_valid}, {127'd0, tv[i].mv});
            chk($sformatf("tv%0d_m_user", i), {127'd0, bus.m_user}, {127'd0, tv[i].mu});
            chk($sformatf("tv%0d_m_last", i), {127'd0, bus.m_last}, {127'd0, tv[i].ml});
            if (tv[i].chkd)
                chk($sformatf("tv%0d_m_data", i), {64'd0, bus.m_data}, {64'd0, tv[i].md});
        end

        // Full frame, no stalls: 1800 contiguous beats, one m_last at the end.
        do_reset(3);
        run_stream(PIX, 100, 100, 3000);
        chk("stream_beats", 128'(beats), 128'd1800);
        chk("stream_span", 128'(last_cyc - first_cyc), 128'd1799);
        chk("stream_last_cnt", 128'(last_cnt), 128'd1);
        chk("stream_last_at", 128'(last_at), 128'd1800);
        chk("stream_user_cnt", 128'(user_cnt), 128'd1);
        chk("stream_fd_pulse", {127'd0, frame_done}, 128'd1);
        chk("stream_fcount", {112'd0, frame_count}, 128'd1);
        @(negedge clk);
        #1;
        chk("stream_fd_drop", {127'd0, frame_done}, 128'd0);

        // Backpressure for 5 cycles on beat 1 of a vector.
        do_reset(2);
        v2 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = v2; bus.m_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {127'd0, bus.m_valid}, 128'd1);
            chk("bp_data", {64'd0, bus.m_data}, {64'd0, v2[127:64]});
            chk("bp_in_ready", {127'd0, bus.in_ready}, 128'd0);
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        #1;
        chk("bp_release_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("bp_release_data", {64'd0, bus.m_data}, {64'd0, v2[127:64]});
        @(negedge clk);
        #1;
        chk("bp_idle", {127'd0, bus.m_valid}, 128'd0);

        // Random traffic over three frames.
        do_reset(2);
        run_stream(3 * PIX, 70, 60, 60000);
        chk("rand_last_cnt", 128'(last_cnt), 128'd3);
        chk("rand_user_cnt", 128'(user_cnt), 128'd3);
        chk("rand_fcount", {112'd0, frame_count}, 128'd3);

        // Reset after beat 0 of pixel 17.
        do_reset(2);
        run_stream(17, 100, 100, 200);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_no_beats", {127'd0, bus.m_valid}, 128'd0);
            @(negedge clk);
        end
        clr_stats();
        run_stream(1, 100, 100, 50);
        chk("rst_sof_user", 128'(user_cnt), 128'd1);
        chk("rst_sof_beats", 128'(beats), 128'd2);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
